uart_fifo: RTL and testbench
============================

Name: uart_fifo

Overview:
Next-generation MMIO UART peripheral: full-duplex TX and RX, 16-bit baud divider, parametrised TX/RX FIFOs, optional parity and 2-stop-bit framing, sticky error flags.
Sits on the shared MMIO bus and is selected by device_select. It is a drop-in bus peer of the existing peripherals, with the same register-window style.
Frames are standard: idle high, start bit 0, data LSB first, optional parity, stop bit(s) 1.

Parameters:
DEVICE_ADDRESS, 3'b011, device_select value this block responds to
FIFO_DEPTH, 8, entries per TX and RX FIFO; power of 2, minimum 2
DATA_BITS, 8, data bits per frame (5..8); byte writes are truncated to this width, reads are zero-extended

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
device_select  in  3  bus device select
mmio_addr  in  16  register offset
mmio_data_in  in  8  write data
mmio_wr  in  1  write strobe, one cycle
mmio_rd  in  1  read strobe, one cycle
rx  in  1  serial input, asynchronous
tx  out  1  serial output
mmio_data_out  out  8  registered read data
irq  out  1  level interrupt

Behaviour:
- Single clock domain. Reset is synchronous and active-high (rst sampled on posedge clk).
- Reset values: tx=1, mmio_data_out=0, irq=0, all registers=0, FIFOs empty, both FSMs IDLE.
- Reset mid-frame: tx=1 on the next cycle; FIFOs are flushed.
- Access is decoded only when device_select==DEVICE_ADDRESS. mmio_data_out updates 1 cycle after mmio_rd. Unmapped offsets: writes ignored, reads return 0.
- Register map:
  - 0x0 CR (rw): [0]RXE [1]TXE [2]PEN [3]PODD [4]STOP2 [5]RXIE [6]TXIE.
  - 0x1 SR: [0]RXNE [1]TXIDLE [2]TXFULL [3]RXOVR [4]FERR [5]PERR. Bits [5:3] are sticky and W1C; other bits are read-only.
  - 0x2 CDIV_H (rw), 0x3 CDIV_L (rw).
  - 0x4 DATA_RX (ro): a read pops the RX FIFO. If empty, it returns 0x00 and does not pop.
  - 0x5 DATA_TX (wo): a write pushes the TX FIFO. If full, the write is dropped and the FIFO is unchanged.
  - 0x6 LEVEL (ro): [7:4] TX count, [3:0] RX count, saturating at 15.
- Bit period = CDIV+1 clocks. CDIV=0 gives 1 clock per bit. A CDIV change takes effect at the next bit boundary.
- TX FSM (IDLE→START→DATA→PARITY→STOP→IDLE):
  - IDLE: when TXE=1 and the TX FIFO is non-empty, pop into the shifter and enter START the next cycle.
  - START drives 0; DATA shifts DATA_BITS bits LSB first.
  - PARITY is entered only if PEN=1. It drives even parity (XOR of data), or its inverse if PODD=1.
  - STOP drives 1 for 1 or 2 bit periods (STOP2).
  - Back-to-back frames have no idle gap.
  - TXE cleared mid-frame: the current frame completes, then the FSM holds in IDLE.
  - TXIDLE = FIFO empty AND FSM IDLE.
- RX input: rx passes through a 2-flop synchroniser; the FSM acts on the synchronised value.
- RX FSM (IDLE→START→DATA→PARITY→STOP):
  - IDLE: a falling edge with RXE=1 starts START and waits floor((CDIV+1)/2) clocks.
  - START: if the line is high at the sample point, it is a false start; return to IDLE with no flags.
  - DATA and later bits are sampled every CDIV+1 clocks from the start-bit midpoint. Only one stop bit is checked, regardless of STOP2.
  - Stop bit sampled 0: set FERR and discard the byte.
  - Parity mismatch: set PERR and discard the byte.
  - Otherwise push to the RX FIFO. If the FIFO is full, set RXOVR and drop the new byte; FIFO contents are preserved.
  - RXE cleared mid-frame: abort to IDLE and discard the partial frame.
- Same-cycle pop of a full RX FIFO and push of a new byte: both take effect, no RXOVR. The same rule applies to a TX push and a TX-shifter pop on a full TX FIFO.
- Same-cycle W1C clear and hardware set of one sticky bit: the set wins.
- FIFO pointers wrap modulo FIFO_DEPTH. A FIFO holds exactly FIFO_DEPTH entries.
- irq = (RXIE & RXNE) | (TXIE & TXIDLE) | RXOVR | FERR | PERR. It is registered, 1-cycle latency.

Test Plan:
- Basic TX: rst pulse; CDIV=0x0003; CR=0x02; write 0x5=0x55 → tx low for 4 clocks, then 1,0,1,0,1,0,1,0 at 4 clocks each, then high. TXIDLE=1 after the stop bit.
- TX FIFO fill: CR=0x02; write 9 bytes 0x01..0x09 with FIFO_DEPTH=8 in one burst → the first pop empties a slot, so all 9 are sent in order with no gaps. With TXE=0 the 9th write is dropped, LEVEL[7:4]=8, TXFULL=1.
- Loopback RX: tx tied to rx; CR=0x07 (RXE|TXE|PEN even); send 0xA3 → DATA_RX reads 0xA3, RXNE falls after the pop, PERR=0.
- Errors: drive a frame on rx with a stop bit of 0 → FERR=1 and no push. Write 0x10 to SR → FERR=0. Send a wrong parity bit with PEN=1 → PERR=1.
- RX overflow: receive 9 bytes without reading → RXOVR=1. Reads return the first 8 bytes in order; the 9th read returns 0x00.
- Reset mid-frame: assert rst during DATA bit 3 → tx=1 the next cycle, LEVEL=0x00, SR=0x02.

Source files
------------

// File: rtl/uart_fifo.sv
// uart_fifo: MMIO UART peripheral with TX/RX FIFOs, 16-bit baud divider,
// optional parity, 1 or 2 stop bits and sticky error flags.
//
// Ports:
//   clk            system clock
//   rst            synchronous reset, active-high
//   device_select  bus device select; access decoded when == DEVICE_ADDRESS
//   mmio_addr      register offset
//   mmio_data_in   write data
//   mmio_wr        write strobe (one cycle)
//   mmio_rd        read strobe (one cycle)
//   rx             asynchronous serial input
//   tx             serial output (idle high)
//   mmio_data_out  registered read data, valid the cycle after mmio_rd
//   irq            registered level interrupt
//
// Register map: 0 CR, 1 SR, 2 CDIV_H, 3 CDIV_L, 4 DATA_RX, 5 DATA_TX, 6 LEVEL.
module uart_fifo #(
    parameter logic [2:0]  DEVICE_ADDRESS = 3'b011,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned DATA_BITS      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  device_select,
    input  logic [15:0] mmio_addr,
    input  logic [7:0]  mmio_data_in,
    input  logic        mmio_wr,
    input  logic        mmio_rd,
    input  logic        rx,
    output logic        tx,
    output logic [7:0]  mmio_data_out,
    output logic        irq
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    localparam logic [15:0] ADDR_CR      = 16'h0000;
    localparam logic [15:0] ADDR_SR      = 16'h0001;
    localparam logic [15:0] ADDR_CDIV_H  = 16'h0002;
    localparam logic [15:0] ADDR_CDIV_L  = 16'h0003;
    localparam logic [15:0] ADDR_DATA_RX = 16'h0004;
    localparam logic [15:0] ADDR_DATA_TX = 16'h0005;
    localparam logic [15:0] ADDR_LEVEL   = 16'h0006;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    // ------------------------------------------------------------------
    // Bus decode and control registers
    // ------------------------------------------------------------------
    logic        sel, wr_en, rd_en;
    logic [6:0]  cr;
    logic [15:0] cdiv;
    logic        rxovr, ferr, perr;
    logic [7:0]  rdata;
    logic [7:0]  sr;

    logic cr_rxe, cr_txe, cr_pen, cr_podd, cr_stop2, cr_rxie, cr_txie;

    assign sel   = (device_select == DEVICE_ADDRESS);
    assign wr_en = sel & mmio_wr;
    assign rd_en = sel & mmio_rd;

    assign cr_rxe   = cr[0];
    assign cr_txe   = cr[1];
    assign cr_pen   = cr[2];
    assign cr_podd  = cr[3];
    assign cr_stop2 = cr[4];
    assign cr_rxie  = cr[5];
    assign cr_txie  = cr[6];

    // floor((CDIV+1)/2) without a 17-bit intermediate
    logic [15:0] cdiv_half;
    assign cdiv_half = {1'b0, cdiv[15:1]} + {15'd0, cdiv[0]};

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [AW-1:0]        tx_wptr, tx_rptr;
    logic [CW-1:0]        tx_count;
    logic                 tx_empty, tx_full, tx_push, tx_pop;
    logic [DATA_BITS-1:0] tx_head;

    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == CW'(FIFO_DEPTH));
    assign tx_head  = tx_mem[tx_rptr];
    assign tx_push  = wr_en && (mmio_addr == ADDR_DATA_TX) && (!tx_full || tx_pop);

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wptr] <= mmio_data_in[DATA_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + AW'(1);
            if (tx_pop)  tx_rptr <= tx_rptr + AW'(1);
            if (tx_push && !tx_pop)      tx_count <= tx_count + CW'(1);
            else if (!tx_push && tx_pop) tx_count <= tx_count - CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]        rx_wptr, rx_rptr;
    logic [CW-1:0]        rx_count;
    logic                 rx_empty, rx_full, rx_push, rx_pop;
    logic                 rx_frame_ok;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;

    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == CW'(FIFO_DEPTH));
    assign rx_pop   = rd_en && (mmio_addr == ADDR_DATA_RX) && !rx_empty;
    assign rx_push  = rx_frame_ok && (!rx_full || rx_pop);

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wptr] <= rx_sh_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + AW'(1);
            if (rx_pop)  rx_rptr <= rx_rptr + AW'(1);
            if (rx_push && !rx_pop)      rx_count <= rx_count + CW'(1);
            else if (!rx_push && rx_pop) rx_count <= rx_count - CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // TX FSM
    // ------------------------------------------------------------------
    tx_state_t            tx_state_q, tx_state_d;
    logic [15:0]          tx_cnt_q, tx_cnt_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic [2:0]           tx_idx_q, tx_idx_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_stop2nd_q, tx_stop2nd_d;
    logic                 tx_line_d;
    logic                 tx_load, tx_can_start, tx_bit_end;

    assign tx_can_start = cr_txe && !tx_empty;
    assign tx_bit_end   = (tx_cnt_q == '0);
    assign tx_pop       = tx_load;

    always_comb begin
        tx_state_d   = tx_state_q;
        tx_cnt_d     = tx_cnt_q;
        tx_sh_d      = tx_sh_q;
        tx_idx_d     = tx_idx_q;
        tx_par_d     = tx_par_q;
        tx_stop2nd_d = tx_stop2nd_q;
        tx_load      = 1'b0;
        tx_line_d    = 1'b1;

        case (tx_state_q)
            TX_IDLE: begin
                if (tx_can_start) tx_load = 1'b1;
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = cdiv;
                    tx_idx_d   = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_cnt_d = cdiv;
                    tx_sh_d  = tx_sh_q >> 1;
                    if (tx_idx_q == LAST_BIT) begin
                        tx_state_d   = cr_pen ? TX_PARITY : TX_STOP;
                        tx_stop2nd_d = 1'b0;
                    end else begin
                        tx_idx_d = tx_idx_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_d   = TX_STOP;
                    tx_cnt_d     = cdiv;
                    tx_stop2nd_d = 1'b0;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (cr_stop2 && !tx_stop2nd_q) begin
                        tx_stop2nd_d = 1'b1;
                        tx_cnt_d     = cdiv;
                    end else if (tx_can_start) begin
                        // chain straight into the next start bit: no idle gap
                        tx_load = 1'b1;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        if (tx_load) begin
            tx_state_d   = TX_START;
            tx_cnt_d     = cdiv;
            tx_sh_d      = tx_head;
            tx_par_d     = (^tx_head) ^ cr_podd;
            tx_stop2nd_d = 1'b0;
        end

        // line level is registered alongside the state it belongs to
        case (tx_state_d)
            TX_START:  tx_line_d = 1'b0;
            TX_DATA:   tx_line_d = tx_sh_d[0];
            TX_PARITY: tx_line_d = tx_par_d;
            default:   tx_line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q   <= TX_IDLE;
            tx_cnt_q     <= '0;
            tx_sh_q      <= '0;
            tx_idx_q     <= '0;
            tx_par_q     <= 1'b0;
            tx_stop2nd_q <= 1'b0;
            tx           <= 1'b1;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_sh_q      <= tx_sh_d;
            tx_idx_q     <= tx_idx_d;
            tx_par_q     <= tx_par_d;
            tx_stop2nd_q <= tx_stop2nd_d;
            tx           <= tx_line_d;
        end
    end

    // ------------------------------------------------------------------
    // RX synchroniser and FSM
    // ------------------------------------------------------------------
    logic rx_s1, rx_s2, rx_prev, rx_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall = rx_prev & ~rx_s2;

    rx_state_t   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_idx_q, rx_idx_d;
    logic        rx_pbad_q, rx_pbad_d;
    logic        rx_bit_end;
    logic        set_ferr, set_perr, set_rxovr;

    assign rx_bit_end = (rx_cnt_q == '0);
    assign set_rxovr  = rx_frame_ok && rx_full && !rx_pop;

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_sh_d     = rx_sh_q;
        rx_idx_d    = rx_idx_q;
        rx_pbad_d   = rx_pbad_q;
        rx_frame_ok = 1'b0;
        set_ferr    = 1'b0;
        set_perr    = 1'b0;

        if (rx_state_q != RX_IDLE && !cr_rxe) begin
            rx_state_d = RX_IDLE;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (cr_rxe && rx_fall) begin
                        rx_idx_d  = '0;
                        rx_pbad_d = 1'b0;
                        // The fall cycle is the start-bit sample point when
                        // the half-period wait is zero, so go straight to data.
                        if (cdiv == '0) begin
                            rx_state_d = RX_DATA;
                            rx_cnt_d   = '0;
                        end else begin
                            rx_state_d = RX_START;
                            rx_cnt_d   = cdiv_half - 16'd1;
                        end
                    end
                end
                RX_START: begin
                    if (rx_bit_end) begin
                        if (rx_s2) begin
                            rx_state_d = RX_IDLE;
                        end else begin
                            rx_state_d = RX_DATA;
                            rx_cnt_d   = cdiv;
                        end
                    end else begin
                        rx_cnt_d = rx_cnt_q - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_bit_end) begin
                        rx_sh_d  = {rx_s2, rx_sh_q[DATA_BITS-1:1]};
                        rx_cnt_d = cdiv;
                        if (rx_idx_q == LAST_BIT) begin
                            rx_state_d = cr_pen ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_idx_d = rx_idx_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_d = rx_cnt_q - 16'd1;
                    end
                end
                RX_PARITY: begin
                    if (rx_bit_end) begin
                        rx_pbad_d  = rx_s2 ^ (^rx_sh_q) ^ cr_podd;
                        rx_state_d = RX_STOP;
                        rx_cnt_d   = cdiv;
                    end else begin
                        rx_cnt_d = rx_cnt_q - 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_bit_end) begin
                        rx_state_d = RX_IDLE;
                        if (!rx_s2)                     set_ferr    = 1'b1;
                        else if (cr_pen && rx_pbad_q)   set_perr    = 1'b1;
                        else                            rx_frame_ok = 1'b1;
                    end else begin
                        rx_cnt_d = rx_cnt_q - 16'd1;
                    end
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_sh_q    <= '0;
            rx_idx_q   <= '0;
            rx_pbad_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_sh_q    <= rx_sh_d;
            rx_idx_q   <= rx_idx_d;
            rx_pbad_q  <= rx_pbad_d;
        end
    end

    // ------------------------------------------------------------------
    // Status, read mux, registers, interrupt
    // ------------------------------------------------------------------
    function automatic logic [3:0] sat4(input logic [CW-1:0] c);
        if (int'(c) > 15) return 4'hF;
        return 4'(c);
    endfunction

    logic rxne, txidle;
    assign rxne   = !rx_empty;
    assign txidle = tx_empty && (tx_state_q == TX_IDLE);
    assign sr     = {2'b00, perr, ferr, rxovr, tx_full, txidle, rxne};

    always_comb begin
        rdata = '0;
        case (mmio_addr)
            ADDR_CR:      rdata = {1'b0, cr};
            ADDR_SR:      rdata = sr;
            ADDR_CDIV_H:  rdata = cdiv[15:8];
            ADDR_CDIV_L:  rdata = cdiv[7:0];
            ADDR_DATA_RX: if (!rx_empty) rdata[DATA_BITS-1:0] = rx_mem[rx_rptr];
            ADDR_LEVEL:   rdata = {sat4(tx_count), sat4(rx_count)};
            default:      rdata = '0;
        endcase
    end

    logic sr_w1c;
    assign sr_w1c = wr_en && (mmio_addr == ADDR_SR);

    always_ff @(posedge clk) begin
        if (rst) begin
            cr            <= '0;
            cdiv          <= '0;
            rxovr         <= 1'b0;
            ferr          <= 1'b0;
            perr          <= 1'b0;
            mmio_data_out <= '0;
            irq           <= 1'b0;
        end else begin
            if (wr_en) begin
                case (mmio_addr)
                    ADDR_CR:     cr         <= mmio_data_in[6:0];
                    ADDR_CDIV_H: cdiv[15:8] <= mmio_data_in;
                    ADDR_CDIV_L: cdiv[7:0]  <= mmio_data_in;
                    default: ;
                endcase
            end
            // hardware set takes priority over a same-cycle clear
            rxovr <= (rxovr & ~(sr_w1c & mmio_data_in[3])) | set_rxovr;
            ferr  <= (ferr  & ~(sr_w1c & mmio_data_in[4])) | set_ferr;
            perr  <= (perr  & ~(sr_w1c & mmio_data_in[5])) | set_perr;
            if (rd_en) mmio_data_out <= rdata;
            irq <= (cr_rxie & rxne) | (cr_txie & txidle) | rxovr | ferr | perr;
        end
    end

endmodule

// File: tb/tb_uart_fifo.sv
module tb_uart_fifo;

    localparam logic [2:0]  DEV   = 3'b011;
    localparam logic [15:0] A_CR  = 16'h0000;
    localparam logic [15:0] A_SR  = 16'h0001;
    localparam logic [15:0] A_CH  = 16'h0002;
    localparam logic [15:0] A_CL  = 16'h0003;
    localparam logic [15:0] A_RX  = 16'h0004;
    localparam logic [15:0] A_TX  = 16'h0005;
    localparam logic [15:0] A_LV  = 16'h0006;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  device_select = DEV;
    logic [15:0] mmio_addr = '0;
    logic [7:0]  mmio_data_in = '0;
    logic        mmio_wr = 1'b0;
    logic        mmio_rd = 1'b0;
    logic        rx_drv = 1'b1;
    logic        loop_en = 1'b0;
    logic        rx_line;
    logic        tx;
    logic [7:0]  mmio_data_out;
    logic        irq;

    int errors = 0;
    int checks = 0;

    assign rx_line = loop_en ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_fifo #(.DEVICE_ADDRESS(3'b011), .FIFO_DEPTH(8), .DATA_BITS(8)) dut (
        .clk(clk), .rst(rst), .device_select(device_select), .mmio_addr(mmio_addr),
        .mmio_data_in(mmio_data_in), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
        .rx(rx_line), .tx(tx), .mmio_data_out(mmio_data_out), .irq(irq)
    );

    typedef struct {
        logic [2:0]  sel;
        logic        wr;
        logic [15:0] waddr;
        logic [7:0]  wdata;
        logic [15:0] raddr;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write_sel(input logic [2:0] sel, input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        device_select = sel;
        mmio_addr     = a;
        mmio_data_in  = d;
        mmio_wr       = 1'b1;
        @(posedge clk);
        #1;
        mmio_wr       = 1'b0;
        device_select = DEV;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        bus_write_sel(DEV, a, d);
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
        @(negedge clk);
        device_select = DEV;
        mmio_addr     = a;
        mmio_rd       = 1'b1;
        @(posedge clk);
        #1;
        mmio_rd = 1'b0;
        d       = mmio_data_out;
    endtask

    task automatic read_check(input logic [15:0] a, input logic [7:0] exp, input string name);
        logic [7:0] v;
        bus_read(a, v);
        check(name, v, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mmio_wr = 1'b0;
        mmio_rd = 1'b0;
        rx_drv = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_cdiv(input int c);
        bus_write(A_CH, 8'((c >> 8) & 255));
        bus_write(A_CL, 8'(c & 255));
    endtask

    // Expected serial waveform derived from the frame format: start 0,
    // data LSB first, optional parity, stop bit(s) 1, each CDIV+1 clocks.
    task automatic check_frame(input logic [7:0] d, input bit pen, input bit podd,
                               input bit stop2, input int cdiv, input bit wait_edge,
                               input string name);
        logic exp_bits[12];
        int nb;
        int bad;
        nb = 0;
        exp_bits[nb] = 1'b0; nb++;
        for (int i = 0; i < 8; i++) begin
            exp_bits[nb] = d[i]; nb++;
        end
        if (pen) begin
            exp_bits[nb] = (^d) ^ podd; nb++;
        end
        exp_bits[nb] = 1'b1; nb++;
        if (stop2) begin
            exp_bits[nb] = 1'b1; nb++;
        end
        if (wait_edge) begin
            @(negedge clk);
            for (int t = 0; t < 300 && tx !== 1'b0; t++) @(negedge clk);
            if (tx !== 1'b0) begin
                check({name, " start timeout"}, tx, 0);
                return;
            end
        end
        bad = 0;
        for (int k = 0; k < nb; k++) begin
            for (int c = 0; c <= cdiv; c++) begin
                if (tx !== exp_bits[k]) bad++;
                @(negedge clk);
            end
        end
        check(name, bad, 0);
    endtask

    task automatic drive_frame(input logic [7:0] d, input bit has_par, input bit par_bit,
                               input bit stop_bit, input int cdiv);
        logic bits[11];
        int nb;
        nb = 0;
        bits[nb] = 1'b0; nb++;
        for (int i = 0; i < 8; i++) begin
            bits[nb] = d[i]; nb++;
        end
        if (has_par) begin
            bits[nb] = par_bit; nb++;
        end
        bits[nb] = stop_bit; nb++;
        @(negedge clk);
        for (int k = 0; k < nb; k++) begin
            rx_drv = bits[k];
            repeat (cdiv + 1) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (3 * (cdiv + 1) + 4) @(negedge clk);
    endtask

    task automatic wait_rx(input int n, input string name);
        logic [7:0] v;
        v = '0;
        for (int t = 0; t < 600; t++) begin
            bus_read(A_LV, v);
            if (int'(v[3:0]) >= n) break;
        end
        check(name, v[3:0], n);
    endtask

    task automatic wait_txidle(input string name);
        logic [7:0] v;
        v = '0;
        for (int t = 0; t < 600; t++) begin
            bus_read(A_SR, v);
            if (v[1]) break;
        end
        check(name, v[1], 1);
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] model_q[$];
        int lows;

        vecs[0]  = '{DEV,    1'b1, A_CR,     8'h3C, A_CR,  8'h3C};
        vecs[1]  = '{DEV,    1'b1, A_CH,     8'hAB, A_CH,  8'hAB};
        vecs[2]  = '{DEV,    1'b1, A_CL,     8'hCD, A_CL,  8'hCD};
        vecs[3]  = '{3'b010, 1'b1, A_CH,     8'h11, A_CH,  8'hAB};
        vecs[4]  = '{DEV,    1'b1, 16'h0102, 8'h22, A_CH,  8'hAB};
        vecs[5]  = '{DEV,    1'b0, A_CR,     8'h00, 16'h0102, 8'h00};
        vecs[6]  = '{DEV,    1'b0, A_CR,     8'h00, 16'h0007, 8'h00};
        vecs[7]  = '{DEV,    1'b0, A_CR,     8'h00, A_TX,  8'h00};
        vecs[8]  = '{DEV,    1'b0, A_CR,     8'h00, A_RX,  8'h00};
        vecs[9]  = '{DEV,    1'b1, A_SR,     8'h38, A_SR,  8'h02};
        vecs[10] = '{DEV,    1'b1, A_CR,     8'hFF, A_CR,  8'h7F};

        // reset state
        do_reset();
        check("reset tx", tx, 1);
        check("reset irq", irq, 0);
        check("reset data_out", mmio_data_out, 0);
        read_check(A_SR, 8'h02, "reset SR");
        read_check(A_LV, 8'h00, "reset LEVEL");

        // register table
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) bus_write_sel(vecs[i].sel, vecs[i].waddr, vecs[i].wdata);
            read_check(vecs[i].raddr, vecs[i].exp, $sformatf("reg vec %0d", i));
        end
        // CR=0x7F: TXIE with TX idle raises irq
        repeat (2) @(negedge clk);
        check("irq txie", irq, 1);
        bus_write(A_CR, 8'h00);
        repeat (2) @(negedge clk);
        check("irq cleared", irq, 0);

        // basic TX
        do_reset();
        set_cdiv(3);
        bus_write(A_CR, 8'h02);
        bus_write(A_TX, 8'h55);
        check_frame(8'h55, 0, 0, 0, 3, 1, "basic tx 0x55");
        read_check(A_SR, 8'h02, "basic tx SR idle");

        // TX burst of 9 with TXE=1: all sent back to back
        fork
            begin
                for (int i = 1; i <= 9; i++) bus_write(A_TX, 8'(i));
            end
            begin
                check_frame(8'h01, 0, 0, 0, 3, 1, "burst frame 1");
                for (int i = 2; i <= 9; i++)
                    check_frame(8'(i), 0, 0, 0, 3, 0, $sformatf("burst frame %0d", i));
            end
        join
        read_check(A_SR, 8'h02, "burst SR idle");

        // TX fill with TXE=0: 9th write dropped
        bus_write(A_CR, 8'h00);
        for (int i = 0; i < 9; i++) bus_write(A_TX, 8'(8'h11 + i));
        read_check(A_LV, 8'h80, "fill LEVEL");
        read_check(A_SR, 8'h04, "fill SR TXFULL");
        bus_write(A_CR, 8'h12);
        check_frame(8'h11, 0, 0, 1, 3, 1, "fill frame 0");
        for (int i = 1; i < 8; i++)
            check_frame(8'(8'h11 + i), 0, 0, 1, 3, 0, $sformatf("fill frame %0d", i));
        read_check(A_SR, 8'h02, "fill 9th dropped");

        // loopback RX with even parity
        do_reset();
        loop_en = 1'b1;
        set_cdiv(3);
        bus_write(A_CR, 8'h07);
        bus_write(A_TX, 8'hA3);
        wait_rx(1, "loop wait rx");
        wait_txidle("loop wait tx");
        read_check(A_SR, 8'h03, "loop SR rxne");
        read_check(A_RX, 8'hA3, "loop data");
        read_check(A_SR, 8'h02, "loop SR after pop");

        // RX overflow
        set_cdiv(2);
        bus_write(A_CR, 8'h03);
        for (int i = 0; i < 9; i++) bus_write(A_TX, 8'(8'hC0 + i));
        wait_txidle("ovr wait tx");
        repeat (12) @(negedge clk);
        read_check(A_SR, 8'h0B, "ovr SR");
        read_check(A_LV, 8'h08, "ovr LEVEL");
        check("ovr irq", irq, 1);
        for (int i = 0; i < 8; i++) read_check(A_RX, 8'(8'hC0 + i), $sformatf("ovr read %0d", i));
        read_check(A_RX, 8'h00, "ovr read empty");
        bus_write(A_SR, 8'h08);
        read_check(A_SR, 8'h02, "ovr W1C");

        // framing and parity errors, driven directly on rx
        do_reset();
        loop_en = 1'b0;
        set_cdiv(3);
        bus_write(A_CR, 8'h01);
        drive_frame(8'h5A, 0, 0, 0, 3);
        read_check(A_SR, 8'h12, "ferr SR");
        read_check(A_LV, 8'h00, "ferr no push");
        check("ferr irq", irq, 1);
        bus_write(A_SR, 8'h10);
        read_check(A_SR, 8'h02, "ferr W1C");
        bus_write(A_CR, 8'h05);
        drive_frame(8'h5A, 1, ~(^8'h5A), 1, 3);
        read_check(A_SR, 8'h22, "perr SR");
        read_check(A_LV, 8'h00, "perr no push");
        bus_write(A_SR, 8'h20);
        drive_frame(8'hC3, 1, ^8'hC3, 1, 3);
        read_check(A_SR, 8'h03, "good parity SR");
        read_check(A_RX, 8'hC3, "good parity data");

        // randomized loopback against a queue model
        do_reset();
        loop_en = 1'b1;
        for (int it = 0; it < 10; it++) begin
            int cdiv, n;
            bit pen, podd, stop2;
            cdiv  = $urandom_range(0, 5);
            pen   = 1'($urandom_range(0, 1));
            podd  = 1'($urandom_range(0, 1));
            stop2 = 1'($urandom_range(0, 1));
            n     = $urandom_range(1, 4);
            set_cdiv(cdiv);
            bus_write(A_CR, {3'b000, stop2, podd, pen, 2'b11});
            for (int k = 0; k < n; k++) begin
                logic [7:0] b;
                b = 8'($urandom);
                model_q.push_back(b);
                bus_write(A_TX, b);
            end
            wait_rx(n, $sformatf("rand %0d level", it));
            wait_txidle($sformatf("rand %0d txidle", it));
            read_check(A_SR, 8'h03, $sformatf("rand %0d SR", it));
            while (model_q.size() > 0) begin
                logic [7:0] e;
                e = model_q.pop_front();
                read_check(A_RX, e, $sformatf("rand %0d data", it));
            end
            read_check(A_SR, 8'h02, $sformatf("rand %0d SR empty", it));
        end

        // reset mid-frame during data bit 3
        do_reset();
        loop_en = 1'b0;
        set_cdiv(3);
        bus_write(A_CR, 8'h02);
        for (int i = 0; i < 3; i++) bus_write(A_TX, 8'h00);
        @(negedge clk);
        for (int t = 0; t < 100 && tx !== 1'b0; t++) @(negedge clk);
        repeat (4 + 3 * 4 + 1) @(negedge clk);
        check("midframe tx low", tx, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midframe tx after rst", tx, 1);
        read_check(A_LV, 8'h00, "midframe LEVEL");
        read_check(A_SR, 8'h02, "midframe SR");
        lows = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("midframe tx stays high", lows, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
